// File: rtl/board_pkg.sv
// Shared types and constants for the board task sequencer.
package board_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_HOLD     = 2'd2,
    ST_FINISHED = 2'd3
  } seq_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_BLANK  = 4'hF;

  function automatic logic state_is_busy(input seq_state_e s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Divider counter and registered tick pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CNT_LAST);
      cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/board_task_sequencer.sv
// Steps through NUM_TASKS task channels, muxing each task's display onto seg/an.
// Optional per-task timeout is enabled by defining SEQ_TIMEOUT_EN.
module board_task_sequencer
  import board_pkg::*;
#(
  parameter int NUM_TASKS     = 4,
  parameter int CLK_HZ        = 100000000,
  parameter int TICK_HZ       = 1000,
  parameter int HOLD_TICKS    = 500,
  parameter int TIMEOUT_TICKS = 30000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         skip,
  input  logic [8*NUM_TASKS-1:0]       task_seg,
  input  logic [4*NUM_TASKS-1:0]       task_an,
  input  logic [NUM_TASKS-1:0]         task_done,
  output logic [7:0]                   seg,
  output logic [3:0]                   an,
  output logic [NUM_TASKS-1:0]         task_start,
  output logic [$clog2(NUM_TASKS)-1:0] active_task,
  output logic [NUM_TASKS-1:0]         progress,
  output logic                         tick,
  output logic                         busy,
  output logic [NUM_TASKS-1:0]         timed_out
);

  localparam int AW = $clog2(NUM_TASKS);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [AW-1:0] TASK_LAST = AW'(NUM_TASKS - 1);

  seq_state_e           state_q, state_d;
  logic [AW-1:0]        active_q, active_d;
  logic [NUM_TASKS-1:0] progress_q, progress_d;
  logic [NUM_TASKS-1:0] task_start_q, task_start_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 start_q, skip_q;
  logic [7:0]           seg_q;
  logic [3:0]           an_q;
  logic                 tick_s, start_rise_s, skip_rise_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
  logic [TW-1:0]        to_q, to_d;
  logic [NUM_TASKS-1:0] timed_out_q, timed_out_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = TIMEOUT_TICKS[0];
`endif

  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .tick (tick_s)
  );

  assign start_rise_s = start & ~start_q;
  assign skip_rise_s  = skip & ~skip_q;

  // Next-state and task bookkeeping
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    progress_d   = progress_q;
    task_start_d = '0;
    hold_d       = hold_q;
`ifdef SEQ_TIMEOUT_EN
    to_d         = to_q;
    timed_out_d  = timed_out_q;
`endif
    case (state_q)
      ST_IDLE, ST_FINISHED: begin
        if (start_rise_s) begin
          state_d      = ST_RUN;
          active_d     = '0;
          progress_d   = '0;
          task_start_d = NUM_TASKS'(1);
`ifdef SEQ_TIMEOUT_EN
          to_d         = '0;
          timed_out_d  = '0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        // done and skip together still give a single transition into HOLD
        if (task_done[active_q] || skip_rise_s) begin
          state_d = ST_HOLD;
          hold_d  = '0;
`ifdef SEQ_TIMEOUT_EN
        end else if (tick_s && (to_q == TO_LAST)) begin
          state_d                = ST_HOLD;
          hold_d                 = '0;
          timed_out_d[active_q]  = 1'b1;
        end else if (tick_s) begin
          to_d = to_q + 1'b1;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (tick_s && (hold_q == HOLD_LAST)) begin
          progress_d[active_q] = 1'b1;
          if (active_q == TASK_LAST) begin
            state_d = ST_FINISHED;
          end else begin
            state_d      = ST_RUN;
            active_d     = active_q + 1'b1;
            task_start_d = NUM_TASKS'(1) << (active_q + 1'b1);
`ifdef SEQ_TIMEOUT_EN
            to_d         = '0;
`endif
          end
        end else if (tick_s) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = hold_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, edge-detect and registered display outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      active_q     <= '0;
      progress_q   <= '0;
      task_start_q <= '0;
      hold_q       <= '0;
      start_q      <= 1'b0;
      skip_q       <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_BLANK;
`ifdef SEQ_TIMEOUT_EN
      to_q         <= '0;
      timed_out_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      progress_q   <= progress_d;
      task_start_q <= task_start_d;
      hold_q       <= hold_d;
      start_q      <= start;
      skip_q       <= skip;
      seg_q        <= (state_q == ST_IDLE) ? SEG_BLANK : task_seg[{active_q, 3'b000} +: 8];
      an_q         <= (state_q == ST_IDLE) ? AN_BLANK  : task_an[{active_q, 2'b00} +: 4];
`ifdef SEQ_TIMEOUT_EN
      to_q         <= to_d;
      timed_out_q  <= timed_out_d;
`endif
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign task_start  = task_start_q;
  assign active_task = active_q;
  assign progress    = progress_q;
  assign tick        = tick_s;
  assign busy        = state_is_busy(state_q);
`ifdef SEQ_TIMEOUT_EN
  assign timed_out   = timed_out_q;
`else
  assign timed_out   = '0;
`endif

endmodule

// File: tb/tb_board_task_sequencer.sv
// Self-checking bench: vector table with a scoreboard queue plus hand sequences.
module tb_board_task_sequencer;

  localparam int NT = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            skip  = 1'b0;
  logic [8*NT-1:0] task_seg;
  logic [4*NT-1:0] task_an;
  logic [NT-1:0]   task_done = '0;
  logic [7:0]      seg;
  logic [3:0]      an;
  logic [NT-1:0]   task_start;
  logic [1:0]      active_task;
  logic [NT-1:0]   progress;
  logic            tick;
  logic            busy;
  logic [NT-1:0]   timed_out;

  typedef struct {
    logic       busy;
    logic [1:0] active;
    logic [2:0] progress;
    logic [7:0] seg;
    logic [3:0] an;
    logic [2:0] tmo;
  } exp_t;

  typedef struct {
    logic       start;
    logic       skip;
    logic [2:0] done;
    int         wait_cyc;
    exp_t       exp;
  } vec_t;

  vec_t tbl[8];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ts_cnt[NT];

  assign task_seg = {8'hA2, 8'hA1, 8'hA0};
  assign task_an  = {4'hB, 4'hD, 4'hE};

  board_task_sequencer #(
    .NUM_TASKS(NT), .CLK_HZ(1000), .TICK_HZ(100), .HOLD_TICKS(2), .TIMEOUT_TICKS(5)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .skip(skip),
    .task_seg(task_seg), .task_an(task_an), .task_done(task_done),
    .seg(seg), .an(an), .task_start(task_start), .active_task(active_task),
    .progress(progress), .tick(tick), .busy(busy), .timed_out(timed_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    for (int k = 0; k < NT; k++) if (task_start[k] === 1'b1) ts_cnt[k]++;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic cmp_exp(input string tag, input exp_t e);
    check({tag, ".busy"},     busy,        e.busy);
    check({tag, ".active"},   active_task, e.active);
    check({tag, ".progress"}, progress,    e.progress);
    check({tag, ".seg"},      seg,         e.seg);
    check({tag, ".an"},       an,          e.an);
    check({tag, ".timedout"}, timed_out,   e.tmo);
  endtask

  function automatic exp_t mk(input logic b, input logic [1:0] a, input logic [2:0] p,
                              input logic [7:0] s, input logic [3:0] n);
    exp_t e;
    e.busy = b; e.active = a; e.progress = p; e.seg = s; e.an = n; e.tmo = 3'b000;
    return e;
  endfunction

  initial begin
    int   n;
    int   pulses;
    exp_t e;

    tbl[0] = '{1'b0, 1'b0, 3'b000,  2, mk(1'b1, 2'd0, 3'b000, 8'hA0, 4'hE)};
    tbl[1] = '{1'b0, 1'b0, 3'b001, 25, mk(1'b1, 2'd1, 3'b001, 8'hA1, 4'hD)};
    tbl[2] = '{1'b0, 1'b1, 3'b010,  3, mk(1'b1, 2'd1, 3'b001, 8'hA1, 4'hD)};
    tbl[3] = '{1'b0, 1'b1, 3'b000, 22, mk(1'b1, 2'd2, 3'b011, 8'hA2, 4'hB)};
    tbl[4] = '{1'b0, 1'b0, 3'b100, 25, mk(1'b0, 2'd2, 3'b111, 8'hA2, 4'hB)};
    tbl[5] = '{1'b0, 1'b1, 3'b000,  3, mk(1'b0, 2'd2, 3'b111, 8'hA2, 4'hB)};
    tbl[6] = '{1'b0, 1'b0, 3'b001,  3, mk(1'b0, 2'd2, 3'b111, 8'hA2, 4'hB)};
    tbl[7] = '{1'b1, 1'b0, 3'b000,  3, mk(1'b1, 2'd0, 3'b000, 8'hA0, 4'hE)};

    // reset and idle state
    cycles(3);
    cmp_exp("reset", mk(1'b0, 2'd0, 3'b000, 8'hFF, 4'hF));
    check("reset.task_start", task_start, 3'b000);
    check("reset.tick", tick, 1'b0);
    reset = 1'b0;
    cycles(4);
    check("idle.seg", seg, 8'hFF);
    check("idle.busy", busy, 1'b0);

    // tick period and width
    n = 0;
    while (tick !== 1'b1 && n < 30) begin cyc(); n++; end
    check("tick.seen", tick, 1'b1);
    cyc();
    check("tick.one_cycle", tick, 1'b0);
    n = 1;
    while (tick !== 1'b1 && n < 30) begin cyc(); n++; end
    check("tick.period", n, 10);

    // start held for 5 cycles gives a single pulse
    pulses = 0;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) start = 1'b0;
      cyc();
      if (task_start[0] === 1'b1) pulses++;
    end
    check("start.pulses", pulses, 1);
    check("start.active", active_task, 2'd0);
    check("start.busy", busy, 1'b1);

    // table-driven sequence through all tasks, FINISHED and restart
    for (int k = 0; k < NT; k++) ts_cnt[k] = 0;
    for (int i = 0; i < 8; i++) begin
      start     = tbl[i].start;
      skip      = tbl[i].skip;
      task_done = tbl[i].done;
      sb.push_back(tbl[i].exp);
      cyc();
      start = 1'b0; skip = 1'b0; task_done = '0;
      cycles(tbl[i].wait_cyc - 1);
      e = sb.pop_front();
      cmp_exp($sformatf("vec%0d", i), e);
    end
    check("ts_cnt0", ts_cnt[0], 1);
    check("ts_cnt1", ts_cnt[1], 1);
    check("ts_cnt2", ts_cnt[2], 1);

    // timeout behaviour in task 0 (3 cycles into RUN here)
    cycles(32);
    check("to.early_active", active_task, 2'd0);
    check("to.early_flag", timed_out, 3'b000);
    cycles(45);
`ifdef SEQ_TIMEOUT_EN
    check("to.flag", timed_out, 3'b001);
    check("to.active", active_task, 2'd1);
    check("to.progress", progress, 3'b001);
`else
    check("to.flag", timed_out, 3'b000);
    check("to.active", active_task, 2'd0);
    cycles(1000);
    check("to.still_run", busy, 1'b1);
    check("to.still_active", active_task, 2'd0);
`endif

    // reset in the middle of HOLD for task 1
    reset = 1'b1; cyc(); reset = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cycles(2);
    task_done = 3'b001; cyc(); task_done = '0;
    cycles(24);
    check("rst.pre_active", active_task, 2'd1);
    task_done = 3'b010; cyc(); task_done = '0;
    cycles(3);
    check("rst.pre_busy", busy, 1'b1);
    reset = 1'b1; cyc(); reset = 1'b0;
    cmp_exp("rst", mk(1'b0, 2'd0, 3'b000, 8'hFF, 4'hF));
    check("rst.task_start", task_start, 3'b000);
    cycles(2);
    check("rst.idle_seg", seg, 8'hFF);
    check("rst.idle_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
